// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin arbiter and Clause-22 frame sequencer for two MDIO clients
module mdio_arbiter #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req0_rd,
    input  logic [4:0]  req0_phy,
    input  logic [4:0]  req0_reg,
    input  logic [15:0] req0_wdata,
    input  logic        req1,
    input  logic        req1_rd,
    input  logic [4:0]  req1_phy,
    input  logic [4:0]  req1_reg,
    input  logic [15:0] req1_wdata,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rd_data,
    output logic        timeout_err,
    output logic [31:0] t_data,
    output logic        mdio_start,
    output logic        activado,
    input  logic        mdio_done,
    input  logic [15:0] mdio_rd_data
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [15:0] LAST = 16'(TIMEOUT_CYC - 1);
    state_t      state;
    logic        rr, cur, cur_rd, win, w_rd;
    logic [4:0]  w_phy, w_reg;
    logic [15:0] w_wdata, cnt;
    logic [31:0] frame;
    // winner select and frame build; in DONE the pointer has effectively already moved on
    always_comb begin
        win     = (req0 && req1) ? ((state == DONE) ? ~rr : rr) : req1;
        w_rd    = win ? req1_rd : req0_rd;
        w_phy   = win ? req1_phy : req0_phy;
        w_reg   = win ? req1_reg : req0_reg;
        w_wdata = win ? req1_wdata : req0_wdata;
        frame   = {2'b01, w_rd ? 2'b10 : 2'b01, w_phy, w_reg, w_rd ? 2'b00 : 2'b10, w_rd ? 16'h0000 : w_wdata};
    end
    // sequencer: grant from IDLE or straight out of DONE, wait for completion or timeout, report
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr          <= 1'b0;
            cur         <= 1'b0;
            cur_rd      <= 1'b0;
            cnt         <= 16'h0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            timeout_err <= 1'b0;
            mdio_start  <= 1'b0;
            activado    <= 1'b0;
            t_data      <= 32'h0;
            rd_data     <= 16'h0;
        end else begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            mdio_start  <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (state == DONE) rr <= ~rr;
                    if (req0 || req1) begin
                        state      <= WAIT;
                        ack0       <= ~win;
                        ack1       <= win;
                        cur        <= win;
                        cur_rd     <= w_rd;
                        t_data     <= frame;
                        mdio_start <= 1'b1;
                        activado   <= 1'b1;
                        cnt        <= 16'h0;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (!mdio_start) cnt <= cnt + 16'd1;
                    if (mdio_done || cnt == LAST) begin
                        state       <= DONE;
                        activado    <= 1'b0;
                        done0       <= ~cur;
                        done1       <= cur;
                        timeout_err <= ~mdio_done;
                        rd_data     <= mdio_done ? (cur_rd ? mdio_rd_data : 16'h0000) : 16'hFFFF;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_arbiter.sv
// tb_mdio_arbiter: directed table, corner sequences and randomized transactions against a transaction-level model
module tb_mdio_arbiter;
    localparam int T = 8;
    logic        clk = 1'b0, reset = 1'b0;
    logic        req0 = 0, req0_rd = 0, req1 = 0, req1_rd = 0;
    logic [4:0]  req0_phy = 0, req0_reg = 0, req1_phy = 0, req1_reg = 0;
    logic [15:0] req0_wdata = 0, req1_wdata = 0, mdio_rd_data = 0;
    logic        mdio_done = 0;
    logic        ack0, ack1, done0, done1, timeout_err, mdio_start, activado;
    logic [15:0] rd_data;
    logic [31:0] t_data;
    int          vectors = 0, miscompares = 0;
    logic        ptr = 1'b0;

    typedef struct {
        logic        c;
        logic        rd;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
        int          k;
        logic [15:0] mrd;
        logic [31:0] exp_t;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tbl[6];

    mdio_arbiter #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req0_rd(req0_rd), .req0_phy(req0_phy), .req0_reg(req0_reg), .req0_wdata(req0_wdata),
        .req1(req1), .req1_rd(req1_rd), .req1_phy(req1_phy), .req1_reg(req1_reg), .req1_wdata(req1_wdata),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .rd_data(rd_data),
        .timeout_err(timeout_err), .t_data(t_data), .mdio_start(mdio_start), .activado(activado),
        .mdio_done(mdio_done), .mdio_rd_data(mdio_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] frame(input logic rd, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd);
        return {2'b01, rd ? 2'b10 : 2'b01, phy, rg, rd ? 2'b00 : 2'b10, rd ? 16'h0000 : wd};
    endfunction

    function automatic logic [15:0] exp_rdata(input int k, input logic rd, input logic [15:0] mrd);
        return (k > T) ? 16'hFFFF : (rd ? mrd : 16'h0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_chk(input string name);
        chk(name, {25'h0, ack0, ack1, done0, done1, timeout_err, mdio_start, activado}, 32'h0);
    endtask

    // called at a negedge where the request(s) are already driven; k = cycle offset of mdio_done after the ack cycle
    task automatic serve(input logic w, input logic [31:0] exp_t, input int k, input logic [15:0] mrd,
                         input logic [15:0] exp_rd, input logic exp_err, input logic hold);
        int fin;
        @(negedge clk);
        chk("ack", {30'h0, ack1, ack0}, w ? 32'h2 : 32'h1);
        chk("start_act", {30'h0, mdio_start, activado}, 32'h3);
        chk("t_data", t_data, exp_t);
        if (!hold) begin
            if (w) req1 = 1'b0;
            else req0 = 1'b0;
        end
        fin = (k <= T) ? k + 1 : T + 1;
        for (int i = 0; i < fin; i++) begin
            mdio_done = (i == k);
            mdio_rd_data = (i == k) ? mrd : 16'($urandom);
            @(negedge clk);
            if (i < fin - 1)
                chk("wait", {25'h0, ack0, ack1, done0, done1, timeout_err, mdio_start, activado}, 32'h1);
        end
        chk("done", {30'h0, done1, done0}, w ? 32'h2 : 32'h1);
        chk("timeout_err", {31'h0, timeout_err}, {31'h0, exp_err});
        chk("rd_data", {16'h0, rd_data}, {16'h0, exp_rd});
        chk("done_quiet", {28'h0, activado, mdio_start, ack0, ack1}, 32'h0);
        ptr = ~ptr;
        mdio_done = (k == T + 1);
        mdio_rd_data = 16'($urandom);
    endtask

    function automatic logic pick();
        return (req0 && req1) ? ptr : req1;
    endfunction

    task automatic raise(input logic c);
        if (c) begin
            req1 = 1'b1; req1_rd = 1'($urandom); req1_phy = 5'($urandom); req1_reg = 5'($urandom); req1_wdata = 16'($urandom);
        end else begin
            req0 = 1'b1; req0_rd = 1'($urandom); req0_phy = 5'($urandom); req0_reg = 5'($urandom); req0_wdata = 16'($urandom);
        end
    endtask

    initial begin
        logic w, rd;
        logic [31:0] et;
        logic [15:0] mrd;
        int k, sel;
        tbl[0] = '{1'b0, 1'b0, 5'h03, 5'h1F, 16'hA5A5, 2,     16'hBEEF, 32'h51FEA5A5, 16'h0000, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 5'h01, 5'h02, 16'h0000, 3,     16'h1234, 32'h60880000, 16'h1234, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 5'h00, 5'h00, 16'hFFFF, T + 1, 16'h7777, 32'h5002FFFF, 16'hFFFF, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 5'h1F, 5'h1F, 16'h0000, T,     16'hABCD, 32'h6FFC0000, 16'hABCD, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 5'h0A, 5'h05, 16'h9999, 0,     16'h5555, 32'h65140000, 16'h5555, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 5'h10, 5'h01, 16'h0F0F, T - 1, 16'h4321, 32'h58060F0F, 16'h0000, 1'b0};

        repeat (3) @(negedge clk);
        idle_chk("reset_ctrl");
        chk("reset_t_data", t_data, 32'h0);
        chk("reset_rd_data", {16'h0, rd_data}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        idle_chk("post_reset_idle");

        foreach (tbl[i]) begin
            if (tbl[i].c) begin
                req1 = 1'b1; req1_rd = tbl[i].rd; req1_phy = tbl[i].phy; req1_reg = tbl[i].rg; req1_wdata = tbl[i].wd;
            end else begin
                req0 = 1'b1; req0_rd = tbl[i].rd; req0_phy = tbl[i].phy; req0_reg = tbl[i].rg; req0_wdata = tbl[i].wd;
            end
            serve(tbl[i].c, tbl[i].exp_t, tbl[i].k, tbl[i].mrd, tbl[i].exp_rd, tbl[i].exp_err, 1'b0);
            @(negedge clk);
            mdio_done = 1'b0;
            idle_chk("tbl_gap");
        end

        // a request dropped before it is acked is never served
        req0 = 1'b1; req0_rd = 1'b0; req0_phy = 5'h02; req0_reg = 5'h04; req0_wdata = 16'h0001;
        @(negedge clk);
        chk("drop_ack0", {30'h0, ack1, ack0}, 32'h1);
        req0 = 1'b0; req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0; mdio_done = 1'b1;
        @(negedge clk);
        mdio_done = 1'b0;
        chk("drop_done0", {30'h0, done1, done0}, 32'h1);
        ptr = ~ptr;
        repeat (3) begin
            @(negedge clk);
            idle_chk("drop_never_served");
        end

        // contention from reset release: grants alternate 0,1,0,1, each one cycle after the previous done
        reset = 1'b0;
        @(negedge clk);
        ptr = 1'b0;
        req0 = 1'b1; req0_rd = 1'b0; req0_phy = 5'h02; req0_reg = 5'h03; req0_wdata = 16'h1111;
        req1 = 1'b1; req1_rd = 1'b1; req1_phy = 5'h04; req1_reg = 5'h05; req1_wdata = 16'h2222;
        reset = 1'b1;
        for (int g = 0; g < 4; g++) begin
            w = 1'(g % 2);
            chk("rr_model", {31'h0, pick()}, {31'h0, w});
            et = w ? frame(1'b1, 5'h04, 5'h05, 16'h2222) : frame(1'b0, 5'h02, 5'h03, 16'h1111);
            serve(w, et, 1, 16'h00C0 + 16'(g), w ? 16'h00C0 + 16'(g) : 16'h0000, 1'b0, 1'b1);
        end
        req0 = 1'b0; req1 = 1'b0; mdio_done = 1'b0;
        @(negedge clk);
        idle_chk("contention_end");

        // asynchronous reset in WAIT: everything clears at once and no done follows
        req0 = 1'b1; req0_rd = 1'b1; req0_phy = 5'h07; req0_reg = 5'h08;
        @(negedge clk);
        chk("midrst_ack0", {31'h0, ack0}, 32'h1);
        req0 = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        idle_chk("midrst_ctrl");
        chk("midrst_t_data", t_data, 32'h0);
        chk("midrst_rd_data", {16'h0, rd_data}, 32'h0);
        mdio_done = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        ptr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            mdio_done = 1'b0;
            idle_chk("midrst_no_done");
        end
        req0 = 1'b1; req0_rd = 1'b0; req0_phy = 5'h01; req0_reg = 5'h01; req0_wdata = 16'hCAFE;
        req1 = 1'b1; req1_rd = 1'b1; req1_phy = 5'h02; req1_reg = 5'h02;
        serve(1'b0, frame(1'b0, 5'h01, 5'h01, 16'hCAFE), 2, 16'h0, 16'h0, 1'b0, 1'b0);
        serve(1'b1, frame(1'b1, 5'h02, 5'h02, 16'h0), 1, 16'h4444, 16'h4444, 1'b0, 1'b0);

        // randomized transactions
        for (int n = 0; n < 60; n++) begin
            if (!req0 && !req1) begin
                repeat ($urandom_range(0, 2)) begin
                    mdio_done = 1'($urandom);
                    @(negedge clk);
                    idle_chk("rand_gap");
                end
                mdio_done = 1'b0;
                sel = $urandom_range(1, 3);
                if (sel[0]) raise(1'b0);
                if (sel[1]) raise(1'b1);
            end else if ($urandom_range(0, 1) == 1) begin
                if (!req0) raise(1'b0);
                else if (!req1) raise(1'b1);
            end
            w = pick();
            rd = w ? req1_rd : req0_rd;
            et = w ? frame(req1_rd, req1_phy, req1_reg, req1_wdata) : frame(req0_rd, req0_phy, req0_reg, req0_wdata);
            k = $urandom_range(0, T + 1);
            mrd = 16'($urandom);
            serve(w, et, k, mrd, exp_rdata(k, rd, mrd), k > T, 1'b0);
        end
        if (req0 || req1) begin
            w = pick();
            rd = w ? req1_rd : req0_rd;
            et = w ? frame(req1_rd, req1_phy, req1_reg, req1_wdata) : frame(req0_rd, req0_phy, req0_reg, req0_wdata);
            serve(w, et, 1, 16'h0BAD, exp_rdata(1, rd, 16'h0BAD), 1'b0, 1'b0);
        end
        mdio_done = 1'b0;
        @(negedge clk);
        idle_chk("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
